uart_cmd_ctrl: RTL

Frame-level command controller behind the UART receiver. It consumes the receiver's byte stream (`rx_data` and its one-cycle `rx_data_valid` strobe) and hunts for a sync byte. It then assembles a fixed 5-byte command frame, checks it, and issues a single register write or read request to the on-chip register bus using a req/ack handshake. It also reports framing errors and recovers from stalled frames with an inter-byte timeout.

---
 rtl/uart_cmd_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: hunts for a sync byte, assembles a 5-byte command frame,
// verifies its checksum and issues one register write/read via req/ack.
// Framing errors are reported with a cause code and a saturating count.
module uart_cmd_ctrl #(
  parameter int unsigned CLK_FRE    = 27,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic       reg_ack,
  output logic       busy,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt
);

  localparam int unsigned TMO_CYCLES = CLK_FRE * TIMEOUT_US;
  localparam int unsigned TMO_W      = $clog2(TMO_CYCLES) + 1;
  localparam int unsigned TMO_LIMIT  = TMO_CYCLES - 1;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  localparam logic [1:0] E_CHK     = 2'd0;
  localparam logic [1:0] E_CMD     = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_REQ
  } state_t;

  state_t           state;
  logic [7:0]       cmd_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             counting_c;
  logic             tmo_hit_c;
  logic             chk_ok_c;
  logic             err_hit_c;
  logic [1:0]       err_sel_c;

  assign counting_c = (state == S_CMD) || (state == S_ADDR) ||
                      (state == S_DATA) || (state == S_CHK);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign tmo_hit_c  = counting_c && !rx_data_valid &&
                      (tmo_cnt == TMO_W'(TMO_LIMIT));
  assign chk_ok_c   = ((cmd_q ^ reg_addr ^ reg_wdata) == rx_data);

  // Error detection: which condition fires this cycle and its cause code.
  always_comb begin
    err_hit_c = 1'b0;
    err_sel_c = E_CHK;
    if (tmo_hit_c) begin
      err_hit_c = 1'b1;
      err_sel_c = E_TIMEOUT;
    end else if (rx_data_valid) begin
      case (state)
        S_CMD: begin
          if (rx_data != CMD_WR && rx_data != CMD_RD) begin
            err_hit_c = 1'b1;
            err_sel_c = E_CMD;
          end
        end
        S_CHK: begin
          if (!chk_ok_c) begin
            err_hit_c = 1'b1;
            err_sel_c = E_CHK;
          end
        end
        S_REQ: begin
          err_hit_c = 1'b1;
          err_sel_c = E_OVERRUN;
        end
        default: ;
      endcase
    end
  end

  // Inter-byte timeout counter: cleared by bytes, state changes and idle states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (rx_data_valid || !counting_c || tmo_hit_c) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Error reporting: one-cycle pulse, sticky cause, saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      err_cnt   <= 8'd0;
    end else begin
      frame_err <= err_hit_c;
      if (err_hit_c) begin
        err_code <= err_sel_c;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  // Frame FSM with registered request, address, data and busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_q     <= 8'd0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_data_valid && rx_data == SYNC_BYTE) begin
            state <= S_CMD;
            busy  <= 1'b1;
          end
        end
        S_CMD: begin
          if (rx_data_valid) begin
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              cmd_q <= rx_data;
              state <= S_ADDR;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else if (tmo_hit_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_ADDR: begin
          if (rx_data_valid) begin
            reg_addr <= rx_data;
            state    <= S_DATA;
          end else if (tmo_hit_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_DATA: begin
          if (rx_data_valid) begin
            reg_wdata <= rx_data;
            state     <= S_CHK;
          end else if (tmo_hit_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_CHK: begin
          if (rx_data_valid) begin
            if (chk_ok_c) begin
              state  <= S_REQ;
              reg_wr <= (cmd_q == CMD_WR);
              reg_rd <= (cmd_q == CMD_RD);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else if (tmo_hit_c) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_REQ: begin
          if (reg_ack) begin
            state  <= S_IDLE;
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          reg_wr <= 1'b0;
          reg_rd <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
